instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage directly upstream of the opcode decoder. Owns the PC,
//  issues word reads to instruction memory with a req/valid handshake, and buffers
//  returned words in a small FIFO. Presents {instr, pc} to decode with valid/stall
//  flow control. Honours branch/jump redirects and HALT.
// PARAMETERS
//  ADDR_W    16      PC / imem address width (word addressed)
//  INSTR_W   32      instruction width; opcode = instr[INSTR_W-1 -: 6]
//  DEPTH     2       prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  0       PC loaded on reset
// PORTS
//  clk           in   1        system clock, rising edge
//  rst_n         in   1        asynchronous active-low reset
//  imem_req      out  1        read request; held until accepted
//  imem_addr     out  ADDR_W   read address, stable while imem_req=1
//  imem_gnt      in   1        request accepted this cycle
//  imem_valid    in   1        read data valid (>=1 cycle after gnt)
//  imem_rdata    in   INSTR_W  read data
//  redirect      in   1        taken branch/jump/call/return: flush and refetch
//  redirect_pc   in   ADDR_W   new fetch target
//  stall         in   1        decode cannot accept this cycle
//  halt          in   1        decode saw HALT; stop fetching
//  instr_valid   out  1        instr_out/pc_out valid for decode
//  instr_out     out  INSTR_W  FIFO head instruction
//  pc_out        out  ADDR_W   address of instr_out
//  halted        out  1        fetch stopped, nothing in flight
//  perf_fetch    out  32       words delivered to decode (see CONFIGURATION)
//  perf_stall    out  32       cycles instr_valid=1 && stall=1
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, FIFO empty, imem_req=0, instr_valid=0, instr_out=0,
//   pc_out=0, halted=0, perf_*=0. First imem_req asserted cycle after rst_n rises.
//  FSM: IDLE -> REQ (imem_req=1) -> WAIT (one request outstanding) -> REQ|IDLE.
//   REQ entered only if FIFO free entries > outstanding count (never overflows).
//   On gnt: REQ->WAIT, fetch_pc <= fetch_pc+1 (mod 2^ADDR_W, 0xFFFF wraps to 0).
//   On imem_valid in WAIT: push {rdata, addr}; -> REQ if space else IDLE.
//   Max one outstanding request. Min latency gnt->instr_valid = valid cycle + 1.
//  Decode handshake: word consumed when instr_valid && !stall; outputs held
//   stable while stall=1. Push and pop same cycle on full FIFO is legal.
//  Redirect (highest priority): FIFO flushed and instr_valid=0 next cycle;
//   fetch_pc <= redirect_pc; an outstanding request is marked squash and its
//   imem_valid data dropped; new req issues once that response returns (or
//   immediately if none outstanding). Redirect during stall still flushes.
//  Halt: no new requests; outstanding response still pushed; FIFO drains
//   normally; halted=1 when no req/outstanding. Sticky until reset or redirect;
//   redirect same cycle as halt: redirect wins, halt ignored.
//  Reset mid-transaction: everything cleared asynchronously; late imem_valid
//   after reset with no outstanding request is ignored.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: perf_fetch/perf_stall are 32-bit saturating counters,
//   cleared on reset only. Undefined: both ports tied to 0, no counter flops.
// TESTING
//  1 Reset, imem 1-cycle latency, stall=0 -> addrs 0,1,2.. issued; pc_out 0,1,2
//    with instr_out = mem[pc]; first instr_valid 3 cycles after reset release.
//  2 stall=1 for 5 cycles with FIFO full -> imem_req=0, instr_out/pc_out held,
//    no words lost or duplicated after stall drops.
//  3 redirect to 0x0040 while request for 0x0005 outstanding -> 0x0005 data
//    dropped, next pc_out = 0x0040, instr_valid=0 the cycle after redirect.
//  4 halt at pc 0x0010 -> no req after; buffered words drain; halted=1;
//    later redirect to 0x0000 resumes fetch, halted=0.
//  5 RESET_PC=0xFFFE -> pc_out 0xFFFE,0xFFFF,0x0000 (wrap).
//  6 IF_PERF_CNT_EN: 10 delivered, 4 stall cycles -> perf_fetch=10,
//    perf_stall=4; without macro both read 0.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage feeding the opcode decoder. Owns the fetch PC,
//   issues single-word reads to instruction memory over a req/gnt/valid
//   handshake (at most one request outstanding) and buffers returned words in
//   a small prefetch FIFO that presents {instr_out, pc_out} to decode.
//
//   Optional feature macro: IF_PERF_CNT_EN
//     defined   -> perf_fetch / perf_stall are 32-bit saturating counters
//     undefined -> both perf ports are tied to zero, no counter flops
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_req/addr              read request, address stable while req is held
//   imem_gnt                   request accepted this cycle
//   imem_valid/rdata           read response (>= 1 cycle after gnt)
//   redirect/redirect_pc       flush FIFO and refetch from redirect_pc
//   stall                      decode cannot accept the head word this cycle
//   halt                       stop issuing new requests (sticky)
//   instr_valid/instr_out/pc_out  FIFO head presented to decode
//   halted                     halted and nothing requested or in flight
//   perf_fetch/perf_stall      words delivered / cycles stalled with valid
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    input  logic               halt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0]   req_addr_reg;      // address of the outstanding request
    logic                squash_reg, squash_next;
    logic                halt_reg, halt_next;

    logic [INSTR_W-1:0]  fifo_instr [DEPTH];
    logic [ADDR_W-1:0]   fifo_pc    [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]      count_reg;
    logic [PTR_W:0]      count_upd, count_after;

    logic pop, push, resp, space_ok, halt_eff;

    assign instr_valid = (count_reg != '0);
    assign instr_out   = instr_valid ? fifo_instr[rd_ptr_reg] : '0;
    assign pc_out      = instr_valid ? fifo_pc[rd_ptr_reg]    : '0;
    assign imem_req    = (state_reg == S_REQ);
    assign imem_addr   = fetch_pc_reg;
    assign halted      = halt_reg && (state_reg == S_IDLE);

    assign pop  = instr_valid && !stall;
    assign resp = (state_reg == S_WAIT) && imem_valid;
    // A squashed or redirected-over response is dropped on the floor.
    assign push = resp && !squash_reg && !redirect;

    assign count_upd   = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign count_after = redirect ? '0 : count_upd;
    // A new request is only issued when its word is guaranteed a slot; since
    // at most one request is ever outstanding, one free slot is enough.
    assign space_ok    = (count_after < DEPTH_C);
    // Redirect in the same cycle as halt wins and clears any pending halt.
    assign halt_eff    = (halt || halt_reg) && !redirect;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        squash_next   = squash_reg;
        halt_next     = redirect ? 1'b0 : (halt_reg || halt);
        case (state_reg)
            S_IDLE: begin
                if (!halt_eff && space_ok) state_next = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_next    = S_WAIT;
                    fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
                    squash_next   = redirect;
                end else if (halt_eff) begin
                    // Withdraw an unaccepted request when halting.
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    squash_next = 1'b0;
                    state_next  = (!halt_eff && space_ok) ? S_REQ : S_IDLE;
                end else if (redirect) begin
                    squash_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (redirect) fetch_pc_next = redirect_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= '0;
            squash_reg   <= 1'b0;
            halt_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            squash_reg   <= squash_next;
            halt_reg     <= halt_next;
            if (state_reg == S_REQ && imem_gnt) req_addr_reg <= fetch_pc_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_upd;
        end
    end

    // Storage needs no reset: the outputs are gated by instr_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_reg] <= imem_rdata;
            fifo_pc[wr_ptr_reg]    <= req_addr_reg;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_reg, perf_stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (pop && perf_fetch_reg != '1)
                perf_fetch_reg <= perf_fetch_reg + 32'd1;
            if (instr_valid && stall && perf_stall_reg != '1)
                perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetch = perf_fetch_reg;
    assign perf_stall = perf_stall_reg;
`else
    assign perf_fetch = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A behavioural memory answers grants
//   after a random latency; the reference model is the architectural stream:
//   decode must see consecutive PCs starting at the reset PC or the latest
//   redirect target, each paired with mem_word(pc), with flush, hold, halt and
//   single-outstanding rules checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [15:0] pc_out;
    logic        halted;
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W   (16),
        .INSTR_W  (32),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt        (halt),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .halted      (halted),
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    // Reference-model state
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    int          first_valid = -1;
    logic [15:0] exp_pc = 16'h0000;
    bit          halt_mode = 0;
    bit          prev_redirect = 0;
    bit          prev_held = 0;
    bit          prev_req_wait = 0;
    logic [31:0] prev_instr = '0;
    logic [15:0] prev_pc = '0;
    logic [15:0] prev_addr = '0;
    int          pops = 0;
    int          stalls = 0;
    bit          force_redir = 0;
    bit          force_halt = 0;
    logic [15:0] force_target = '0;

    // One clock cycle: check what the DUT shows, then drive the next inputs.
    task automatic step(input int gnt_pct, input int lat_max, input int stall_pct,
                        input int redir_pct, input int halt_pct);
        logic [31:0] r;
        bit          do_redir;
        logic [15:0] target;
        @(negedge clk);
        cyc++;
        if (instr_valid && first_valid < 0) first_valid = cyc;

        if (prev_redirect) check("flush_valid", instr_valid, 1'b0);
        if (prev_held) begin
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr", instr_out, prev_instr);
            check("hold_pc", pc_out, prev_pc);
        end
        if (imem_req) check("one_outstanding", pend_addr.size(), 0);
        if (prev_req_wait) begin
            check("req_held", imem_req, 1'b1);
            check("addr_stable", imem_addr, prev_addr);
        end
        if (halt_mode) check("halt_noreq", imem_req, 1'b0);
        check("halted", halted, halt_mode && (pend_addr.size() == 0));

        // Memory response
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end

        // Grant
        imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
        if (imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_max, 1)));
        end

        // Decode side
        stall = ($urandom_range(99) < stall_pct);
        if (instr_valid && !stall) begin
            check("pc_out", pc_out, exp_pc);
            check("instr_out", instr_out, mem_word(exp_pc));
            $display("deliver pc=%04h instr=%08h", pc_out, instr_out);
            exp_pc = exp_pc + 16'd1;
            pops++;
        end
        if (instr_valid && stall) stalls++;

        do_redir = force_redir ||
                   ($urandom_range(99) < (halt_mode ? redir_pct * 4 : redir_pct));
        target = force_target;
        if (!force_redir) begin
            r = $urandom;
            case (r % 3)
                0: target = 16'h0040;
                1: target = 16'hFFFE;
                default: target = r[31:16];
            endcase
        end
        redirect    = do_redir;
        redirect_pc = do_redir ? target : 16'h0000;
        halt        = force_halt || ($urandom_range(99) < halt_pct);
        if (do_redir) begin
            exp_pc    = target;
            halt_mode = 0;
        end else if (halt) begin
            halt_mode = 1;
        end
        force_redir = 0;
        force_halt  = 0;

        prev_redirect = do_redir;
        prev_held     = instr_valid && stall && !do_redir;
        prev_instr    = instr_out;
        prev_pc       = pc_out;
        prev_req_wait = imem_req && !imem_gnt && !do_redir && !halt;
        prev_addr     = imem_addr;
    endtask

    initial begin
        int p0;
        // Reset values
        @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc", pc_out, 16'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_perf_fetch", perf_fetch, 32'h0);
        check("rst_perf_stall", perf_stall, 32'h0);
        rst_n = 1'b1;

        // Test 1: zero-wait memory, no stall -> in-order stream from 0
        for (int i = 0; i < 12; i++) step(100, 1, 0, 0, 0);
        check("first_valid_latency", first_valid, 3);
        check("t1_progress", pops >= 4, 1'b1);

        // Test 2: stall until the FIFO is full; requests stop, head held
        for (int i = 0; i < 12; i++) step(100, 1, 100, 0, 0);
        check("full_noreq", imem_req, 1'b0);
        check("full_valid", instr_valid, 1'b1);
        for (int i = 0; i < 12; i++) step(100, 1, 0, 0, 0);

        // Test 3: redirect to 0x0040 with a request in flight
        for (int i = 0; i < 20 && pend_addr.size() == 0; i++) step(100, 3, 0, 0, 0);
        check("t3_outstanding", pend_addr.size() != 0, 1'b1);
        force_redir = 1; force_target = 16'h0040;
        step(100, 3, 0, 0, 0);
        p0 = pops;
        for (int i = 0; i < 20; i++) step(100, 3, 0, 0, 0);
        check("t3_progress", pops - p0 >= 3, 1'b1);

        // Test 4: halt, drain, then resume by redirect to 0
        force_halt = 1;
        step(100, 2, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(100, 2, 0, 0, 0);
        check("t4_halted", halted, 1'b1);
        check("t4_drained", instr_valid, 1'b0);
        force_redir = 1; force_target = 16'h0000;
        step(100, 2, 0, 0, 0);
        p0 = pops;
        for (int i = 0; i < 15; i++) step(100, 2, 0, 0, 0);
        check("t4_resume_halted", halted, 1'b0);
        check("t4_resume_progress", pops - p0 >= 3, 1'b1);

        // Test 5: wrap 0xFFFE -> 0xFFFF -> 0x0000
        force_redir = 1; force_target = 16'hFFFE;
        step(100, 1, 0, 0, 0);
        p0 = pops;
        for (int i = 0; i < 60 && pops - p0 < 4; i++) step(100, 1, 0, 0, 0);
        check("t5_wrap_progress", pops - p0 >= 4, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) step(70, 3, 30, 3, 2);

        // Final drain from a known target to prove liveness
        force_redir = 1; force_target = 16'h0100;
        step(100, 2, 0, 0, 0);
        p0 = pops;
        for (int i = 0; i < 40; i++) step(100, 2, 0, 0, 0);
        check("final_progress", pops - p0 >= 5, 1'b1);

        // Test 6: performance counters
        @(negedge clk);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, pops);
        check("perf_stall", perf_stall, stalls);
`else
        check("perf_fetch", perf_fetch, 32'h0);
        check("perf_stall", perf_stall, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
